// File: rtl/lea_arb_pkg.sv
// Shared types and constants for the LEA data-bus arbiter (state encoding, requester indices).
// Used by lea_data_bus_arbiter and lea_rr_pick.
package lea_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_TURN    = 2'd3
    } arb_state_e;

    localparam int   NUM_REQ   = 2;
    localparam logic REQ_TRAIN = 1'b0;
    localparam logic REQ_INFER = 1'b1;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lea_rr_pick.sv
// Two-way round-robin winner selection: on contention the requester that did not win last time
// is chosen; a lone request always wins.
module lea_rr_pick
    import lea_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               last_i,
    output logic [NUM_REQ-1:0] win_o
);

    always_comb begin
        win_o = req_i;
        if (&req_i) begin
            win_o = req_onehot(~last_i);
        end
    end

endmodule

// File: rtl/lea_data_bus_arbiter.sv
// Arbitrates two requesters (training / inference) onto a shared tri-state register bus.
// Optional macro LEA_ARB_TURNAROUND_EN inserts a one-cycle bus turnaround state after each transaction.
module lea_data_bus_arbiter
    import lea_arb_pkg::*;
#(
    parameter int NrOfBits = 8,
    parameter int NrOfRegs = 4,
    parameter int AddrBits = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  we,
    input  logic [AddrBits-1:0] addr_0,
    input  logic [AddrBits-1:0] addr_1,
    input  logic [NrOfBits-1:0] wdata_0,
    input  logic [NrOfBits-1:0] wdata_1,
    input  logic [NrOfBits-1:0] bus_q,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [NUM_REQ-1:0]  ack,
    output logic [NrOfBits-1:0] rdata,
    output logic [NrOfRegs-1:0] reg_cs,
    output logic [NrOfRegs-1:0] reg_ce,
    output logic [NrOfBits-1:0] reg_d
);

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [NrOfBits-1:0] rdata_q;
    logic [NrOfRegs-1:0] cs_q;
    logic [NrOfRegs-1:0] ce_q;
    logic [NrOfBits-1:0] d_q;
    logic                last_q;
    logic                we_q;

    logic [NUM_REQ-1:0]  win;
    logic [AddrBits-1:0] cand_addr;
    logic [NrOfBits-1:0] cand_wdata;
    logic                cand_we;
    logic [NrOfRegs-1:0] cand_hit;

    lea_rr_pick u_rr_pick (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (win)
    );

    assign cand_addr  = win[REQ_INFER] ? addr_1  : addr_0;
    assign cand_wdata = win[REQ_INFER] ? wdata_1 : wdata_0;
    assign cand_we    = win[REQ_INFER] ? we[1]   : we[0];

    // Registers beyond the address range can never be hit; an out-of-range address decodes to no select.
    generate
        for (genvar gi = 0; gi < NrOfRegs; gi++) begin : g_dec
            if (gi < (1 << AddrBits)) begin : g_reach
                assign cand_hit[gi] = (cand_addr == AddrBits'(gi));
            end else begin : g_unreach
                assign cand_hit[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            cs_q    <= '1;
            ce_q    <= '0;
            d_q     <= '0;
            last_q  <= REQ_INFER;   // requester 0 is preferred first
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_ACCESS;
                        gnt_q   <= win;
                        last_q  <= win[REQ_INFER];
                        we_q    <= cand_we;
                        cs_q    <= ~cand_hit;
                        ce_q    <= cand_we ? cand_hit : '0;
                        d_q     <= cand_we ? cand_wdata : '0;
                    end
                end
                ST_ACCESS: begin
                    if (Tick) begin
                        state_q <= ST_RELEASE;
                        ack_q   <= gnt_q;
                        cs_q    <= '1;
                        ce_q    <= '0;
                        d_q     <= '0;
                        // All chip selects high means no register drove the bus.
                        if (!we_q) begin
                            rdata_q <= (&cs_q) ? '0 : bus_q;
                        end
                    end
                end
                ST_RELEASE: begin
                    ack_q <= '0;
                    gnt_q <= '0;
`ifdef LEA_ARB_TURNAROUND_EN
                    state_q <= ST_TURN;
`else
                    state_q <= ST_IDLE;
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign reg_cs = cs_q;
    assign reg_ce = ce_q;
    assign reg_d  = d_q;

endmodule

// File: tb/tb_lea_data_bus_arbiter.sv
// Self-checking bench for lea_data_bus_arbiter: directed vector table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_lea_data_bus_arbiter;

    localparam int NB = 8;
    localparam int NR = 4;
    localparam int AB = 3;
`ifdef LEA_ARB_TURNAROUND_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Tick = 1'b0;
    logic [1:0]    req = '0;
    logic [1:0]    we = '0;
    logic [AB-1:0] addr_0 = '0;
    logic [AB-1:0] addr_1 = '0;
    logic [NB-1:0] wdata_0 = '0;
    logic [NB-1:0] wdata_1 = '0;
    logic [NB-1:0] bus_q = '0;
    logic [1:0]    gnt;
    logic [1:0]    ack;
    logic [NB-1:0] rdata;
    logic [NR-1:0] reg_cs;
    logic [NR-1:0] reg_ce;
    logic [NB-1:0] reg_d;

    always #5 clk = ~clk;

    lea_data_bus_arbiter #(.NrOfBits(NB), .NrOfRegs(NR), .AddrBits(AB)) dut (
        .Clock   (clk),
        .Reset   (Reset),
        .Tick    (Tick),
        .req     (req),
        .we      (we),
        .addr_0  (addr_0),
        .addr_1  (addr_1),
        .wdata_0 (wdata_0),
        .wdata_1 (wdata_1),
        .bus_q   (bus_q),
        .gnt     (gnt),
        .ack     (ack),
        .rdata   (rdata),
        .reg_cs  (reg_cs),
        .reg_ce  (reg_ce),
        .reg_d   (reg_d)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: a pending transaction record plus a few phase flags.
    bit            m_access = 0;
    bit            m_ack = 0;
    int            m_gap = 0;
    int            m_owner = 0;
    int            m_prefer = 0;
    bit            m_we = 0;
    int            m_addr = 0;
    logic [NB-1:0] m_wdata = '0;
    logic [NB-1:0] m_rdata = '0;

    task automatic model_edge();
        if (Reset) begin
            m_access = 0; m_ack = 0; m_gap = 0; m_prefer = 0; m_rdata = '0;
        end else if (m_ack) begin
            m_ack = 0;
            m_gap = GAP;
        end else if (m_access) begin
            if (Tick) begin
                m_access = 0;
                m_ack = 1;
                if (!m_we) m_rdata = (m_addr < NR) ? bus_q : '0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req != 2'b00) begin
            if (req == 2'b11) m_owner = m_prefer;
            else m_owner = req[1] ? 1 : 0;
            m_prefer = 1 - m_owner;
            m_we     = we[m_owner];
            m_addr   = (m_owner == 1) ? int'(addr_1) : int'(addr_0);
            m_wdata  = (m_owner == 1) ? wdata_1 : wdata_0;
            m_access = 1;
        end
    endtask

    task automatic model_check();
        logic [1:0]    e_gnt;
        logic [1:0]    e_ack;
        logic [NR-1:0] e_cs;
        logic [NR-1:0] e_ce;
        e_gnt = (m_access || m_ack) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_ack = m_ack ? e_gnt : 2'b00;
        e_cs = '1;
        e_ce = '0;
        if (m_access && m_addr < NR) begin
            e_cs[m_addr] = 1'b0;
            if (m_we) e_ce[m_addr] = 1'b1;
        end
        cmp("model_gnt", 32'(gnt), 32'(e_gnt));
        cmp("model_ack", 32'(ack), 32'(e_ack));
        cmp("model_cs", 32'(reg_cs), 32'(e_cs));
        cmp("model_ce", 32'(reg_ce), 32'(e_ce));
        cmp("model_rdata", 32'(rdata), 32'(m_rdata));
        if (m_access && m_we) cmp("model_reg_d", 32'(reg_d), 32'(m_wdata));
        cmp("cs_onehot_low", 32'($countones(~reg_cs) <= 1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        logic          rst;
        logic [1:0]    rq, wr;
        logic [AB-1:0] a0, a1;
        logic [NB-1:0] w0, w1, bus;
        logic          tk;
        logic [1:0]    egnt, eack;
        logic [NR-1:0] ecs, ece;
        logic [NB-1:0] erd, ed;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic rst, logic [1:0] rq, logic [1:0] wr, logic [AB-1:0] a0,
                                logic [AB-1:0] a1, logic [NB-1:0] w0, logic [NB-1:0] bus,
                                logic [1:0] egnt, logic [1:0] eack, logic [NR-1:0] ecs,
                                logic [NR-1:0] ece, logic [NB-1:0] erd, logic [NB-1:0] ed);
        vec_t v;
        v.rst = rst; v.rq = rq; v.wr = wr; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = 8'h00;
        v.bus = bus; v.tk = 1'b1; v.egnt = egnt; v.eack = eack; v.ecs = ecs; v.ece = ece;
        v.erd = erd; v.ed = ed;
        return v;
    endfunction

    logic [1:0] grants[$];
    logic [1:0] prev_gnt;
    int         zero_run;

    initial begin
        // Rows: reset, write reg 2, idle, read reg 1 by requester 1, idle, out-of-range read.
        tbl[0]  = mk(1, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 4'b1111, 4'b0000, 8'h00, 8'h00);
        tbl[1]  = mk(0, 2'b01, 2'b01, 2, 0, 8'hA5, 8'h00, 2'b01, 2'b00, 4'b1011, 4'b0100, 8'h00, 8'hA5);
        tbl[2]  = mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b01, 2'b01, 4'b1111, 4'b0000, 8'h00, 8'h00);
        tbl[3]  = mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 4'b1111, 4'b0000, 8'h00, 8'h00);
        tbl[4]  = mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 4'b1111, 4'b0000, 8'h00, 8'h00);
        tbl[5]  = mk(0, 2'b10, 2'b00, 0, 1, 8'h00, 8'h3C, 2'b10, 2'b00, 4'b1101, 4'b0000, 8'h00, 8'h00);
        tbl[6]  = mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h3C, 2'b10, 2'b10, 4'b1111, 4'b0000, 8'h3C, 8'h00);
        tbl[7]  = mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 4'b1111, 4'b0000, 8'h3C, 8'h00);
        tbl[8]  = mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 4'b1111, 4'b0000, 8'h3C, 8'h00);
        tbl[9]  = mk(0, 2'b01, 2'b00, 5, 0, 8'h00, 8'hFF, 2'b01, 2'b00, 4'b1111, 4'b0000, 8'h3C, 8'h00);
        tbl[10] = mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'hFF, 2'b01, 2'b01, 4'b1111, 4'b0000, 8'h00, 8'h00);
        tbl[11] = mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 4'b1111, 4'b0000, 8'h00, 8'h00);

        for (int i = 0; i < 12; i++) begin
            Reset = tbl[i].rst; req = tbl[i].rq; we = tbl[i].wr; addr_0 = tbl[i].a0;
            addr_1 = tbl[i].a1; wdata_0 = tbl[i].w0; wdata_1 = tbl[i].w1; bus_q = tbl[i].bus;
            Tick = tbl[i].tk;
            step();
            $display("vec %0d: gnt=%b ack=%b cs=%b ce=%b rdata=%h", i, gnt, ack, reg_cs, reg_ce, rdata);
            cmp($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].egnt));
            cmp($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].eack));
            cmp($sformatf("tbl%0d_cs", i), 32'(reg_cs), 32'(tbl[i].ecs));
            cmp($sformatf("tbl%0d_ce", i), 32'(reg_ce), 32'(tbl[i].ece));
            cmp($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].erd));
            if (tbl[i].rst || tbl[i].ece != '0)
                cmp($sformatf("tbl%0d_reg_d", i), 32'(reg_d), 32'(tbl[i].ed));
        end

        // Contention: both requesters held; grants alternate, separated by idle (and turnaround) cycles.
        Reset = 1'b1; req = 2'b00; Tick = 1'b1; step();
        Reset = 1'b0; req = 2'b11; we = 2'b00; addr_0 = 0; addr_1 = 3;
        prev_gnt = 2'b00; zero_run = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (gnt == 2'b00) zero_run++;
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                if (grants.size() > 0) cmp("contention_gap", 32'(zero_run), 32'(GAP + 1));
                grants.push_back(gnt);
                $display("contention grant %0d: %b", grants.size(), gnt);
                zero_run = 0;
            end
            prev_gnt = gnt;
        end
        cmp("contention_count", 32'(grants.size() >= 4), 32'd1);
        if (grants.size() >= 4) begin
            cmp("contention_g0", 32'(grants[0]), 32'h1);
            cmp("contention_g1", 32'(grants[1]), 32'h2);
            cmp("contention_g2", 32'(grants[2]), 32'h1);
            cmp("contention_g3", 32'(grants[3]), 32'h2);
        end

        // Tick held low in ACCESS; changed requests must not disturb the latched write.
        Reset = 1'b1; req = 2'b00; step();
        Reset = 1'b0; req = 2'b01; we = 2'b01; addr_0 = 3; wdata_0 = 8'h5A; Tick = 1'b1; step();
        req = 2'b10; we = 2'b00; addr_0 = 1; addr_1 = 0; Tick = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            $display("tick_low cycle %0d: cs=%b ce=%b ack=%b", c, reg_cs, reg_ce, ack);
            cmp("ticklow_cs", 32'(reg_cs), 32'b0111);
            cmp("ticklow_ce", 32'(reg_ce), 32'b1000);
            cmp("ticklow_d", 32'(reg_d), 32'h5A);
            cmp("ticklow_ack", 32'(ack), 32'h0);
        end
        req = 2'b00; Tick = 1'b1; step();
        cmp("ticklow_ack_after", 32'(ack), 32'h1);

        // Reset in ACCESS abandons the transaction.
        Reset = 1'b1; step();
        Reset = 1'b0; req = 2'b01; we = 2'b01; addr_0 = 1; Tick = 1'b0; step();
        cmp("rst_access_cs", 32'(reg_cs), 32'b1101);
        Reset = 1'b1; req = 2'b00; step();
        $display("reset in access: gnt=%b ack=%b cs=%b ce=%b", gnt, ack, reg_cs, reg_ce);
        cmp("rst_gnt", 32'(gnt), 32'h0);
        cmp("rst_cs", 32'(reg_cs), 32'hF);
        cmp("rst_ce", 32'(reg_ce), 32'h0);
        Reset = 1'b0; Tick = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            cmp("rst_no_ack", 32'(ack), 32'h0);
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            Reset   = ($urandom_range(0, 99) == 0);
            req     = 2'($urandom);
            we      = 2'($urandom);
            addr_0  = AB'($urandom);
            addr_1  = AB'($urandom);
            wdata_0 = NB'($urandom);
            wdata_1 = NB'($urandom);
            bus_q   = NB'($urandom);
            Tick    = ($urandom_range(0, 3) != 0);
            step();
            if (ack != 2'b00)
                $display("rand ack %b rdata=%h at cycle %0d", ack, rdata, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
